// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: PC/IF-ID advance, hold or flush; ID/EX load, hold or bubble.
// Handles load-use hazards, EX redirects and data-memory wait with a timeout trap.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ID_Rs, ID_Rt, ID_UsesRt source registers of the instruction in ID
//   EX_Rt, EX_MemtoReg,
//   EX_RegWr, Jump_EX       ID/EX register fields
//   Branch_taken            branch condition true in EX
//   Mem_busy                data memory not ready this cycle
//   PC_Wr, IFID_Wr,
//   IFID_Flush              PC and IF/ID control
//   IDEX_Bubble, IDEX_Hold  ID/EX control
//   Mem_err                 sticky memory-timeout trap flag
//   Stall_cnt, Redir_cnt    saturating performance counters
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic [4:0]       EX_Rt,
    input  logic             EX_MemtoReg,
    input  logic             EX_RegWr,
    input  logic             Branch_taken,
    input  logic             Jump_EX,
    input  logic             Mem_busy,
    output logic             PC_Wr,
    output logic             IFID_Wr,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             IDEX_Hold,
    output logic             Mem_err,
    output logic [CNT_W-1:0] Stall_cnt,
    output logic [CNT_W-1:0] Redir_cnt
);

    localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int TL = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [WW-1:0] TO_LAST = WW'(TL);

    typedef enum logic [1:0] {
        RUN,
        MWAIT,
        ERR
    } state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;

    logic ldu;
    logic redir;
    logic frz;
    logic do_redir;
    logic do_ldu;
    logic timeout;

    assign ldu = EX_MemtoReg & EX_RegWr & (EX_Rt != 5'd0)
               & ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt)));
    assign redir = Branch_taken | Jump_EX;

    // Mutually exclusive decision terms encode the priority
    // Mem_busy > redirect > load-use; ERR freezes unconditionally.
    assign frz      = (state == ERR) | Mem_busy;
    assign do_redir = ~frz & redir;
    assign do_ldu   = ~frz & ~redir & ldu;

    // The edge that completes the MEM_TIMEOUT-th busy cycle traps.
    assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST);

    always_comb begin
        PC_Wr       = 1'b1;
        IFID_Wr     = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        IDEX_Hold   = 1'b0;
        if (!rst_n) begin
            PC_Wr       = 1'b0;
            IFID_Wr     = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
        end else begin
            unique case (1'b1)
                frz: begin
                    PC_Wr     = 1'b0;
                    IFID_Wr   = 1'b0;
                    IDEX_Hold = 1'b1;
                end
                do_redir: begin
                    IFID_Flush  = 1'b1;
                    IDEX_Bubble = 1'b1;
                end
                do_ldu: begin
                    PC_Wr       = 1'b0;
                    IFID_Wr     = 1'b0;
                    IDEX_Bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            Mem_err   <= 1'b0;
            Stall_cnt <= '0;
            Redir_cnt <= '0;
        end else begin
            if (!PC_Wr && !(&Stall_cnt))
                Stall_cnt <= Stall_cnt + CNT_W'(1);
            if (do_redir && !(&Redir_cnt))
                Redir_cnt <= Redir_cnt + CNT_W'(1);
            if (state != ERR) begin
                if (Mem_busy) begin
                    if (timeout) begin
                        state   <= ERR;
                        Mem_err <= 1'b1;
                    end else begin
                        state <= MWAIT;
                    end
                    // Only reachable as a limit when the timeout is disabled.
                    if (!(&wait_cnt))
                        wait_cnt <= wait_cnt + WW'(1);
                end else begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: behavioural model plus directed vectors.
// Instance uses MEM_TIMEOUT=4 and CNT_W=4 to reach timeout and saturation.
module tb_pipe_hazard_ctrl;

    localparam int TO  = 4;
    localparam int CW  = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    ID_Rs, ID_Rt, EX_Rt;
    logic          ID_UsesRt, EX_MemtoReg, EX_RegWr;
    logic          Branch_taken, Jump_EX, Mem_busy;
    logic          PC_Wr, IFID_Wr, IFID_Flush, IDEX_Bubble, IDEX_Hold;
    logic          Mem_err;
    logic [CW-1:0] Stall_cnt, Redir_cnt;

    int errors = 0;
    int checks = 0;

    // model state
    int m_wait  = 0;
    bit m_err   = 0;
    int m_stall = 0;
    int m_redir = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_Rt(EX_Rt), .EX_MemtoReg(EX_MemtoReg), .EX_RegWr(EX_RegWr),
        .Branch_taken(Branch_taken), .Jump_EX(Jump_EX), .Mem_busy(Mem_busy),
        .PC_Wr(PC_Wr), .IFID_Wr(IFID_Wr), .IFID_Flush(IFID_Flush),
        .IDEX_Bubble(IDEX_Bubble), .IDEX_Hold(IDEX_Hold),
        .Mem_err(Mem_err), .Stall_cnt(Stall_cnt), .Redir_cnt(Redir_cnt)
    );

    always #5 clk = ~clk;

    // Expected {PC_Wr, IFID_Wr, IFID_Flush, IDEX_Bubble, IDEX_Hold}
    function automatic logic [4:0] model_outs();
        bit hz;
        hz = EX_MemtoReg && EX_RegWr && EX_Rt != 0 &&
             (EX_Rt == ID_Rs || (ID_UsesRt && EX_Rt == ID_Rt));
        if (!rst_n)                   return 5'b00110;
        if (m_err || Mem_busy)        return 5'b00001;
        if (Branch_taken || Jump_EX)  return 5'b11110;
        if (hz)                       return 5'b00010;
        return 5'b11000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [4:0] e;
        if (!rst_n) begin
            m_wait = 0; m_err = 0; m_stall = 0; m_redir = 0;
        end else begin
            e = model_outs();
            if (!e[4] && m_stall < MAXC) m_stall = m_stall + 1;
            if (!m_err) begin
                if (Mem_busy) begin
                    m_wait = m_wait + 1;
                    if (m_wait == TO) m_err = 1;
                end else begin
                    m_wait = 0;
                    if ((Branch_taken || Jump_EX) && m_redir < MAXC)
                        m_redir = m_redir + 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic [4:0] e, a;
        e = model_outs();
        a = {PC_Wr, IFID_Wr, IFID_Flush, IDEX_Bubble, IDEX_Hold};
        checks = checks + 1;
        if (a !== e || Mem_err !== m_err ||
            int'(Stall_cnt) != m_stall || int'(Redir_cnt) != m_redir) begin
            errors = errors + 1;
            $display("FAIL model t=%0t outs=%b/%b err=%b/%b stall=%0d/%0d redir=%0d/%0d",
                     $time, a, e, Mem_err, m_err, Stall_cnt, m_stall,
                     Redir_cnt, m_redir);
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic clr_in();
        ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0; EX_Rt = 0;
        EX_MemtoReg = 0; EX_RegWr = 0;
        Branch_taken = 0; Jump_EX = 0; Mem_busy = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_in();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        clr_in();
        #3;
        lit("rst_pcwr", PC_Wr, 0);
        lit("rst_flush", IFID_Flush, 1);
        lit("rst_bubble", IDEX_Bubble, 1);
        lit("rst_hold", IDEX_Hold, 0);
        lit("rst_stall", Stall_cnt, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // load-use on Rs
        EX_MemtoReg = 1; EX_RegWr = 1; EX_Rt = 5; ID_Rs = 5;
        #1;
        lit("ldu_pcwr", PC_Wr, 0);
        lit("ldu_ifidwr", IFID_Wr, 0);
        lit("ldu_bubble", IDEX_Bubble, 1);
        cyc();
        EX_MemtoReg = 0; EX_RegWr = 0; EX_Rt = 0;
        #1;
        lit("ldu_after_pcwr", PC_Wr, 1);
        lit("ldu_stall_cnt", Stall_cnt, 1);
        cyc();

        // EX_Rt = 0 never stalls
        EX_MemtoReg = 1; EX_RegWr = 1; EX_Rt = 0; ID_Rs = 0;
        #1;
        lit("r0_pcwr", PC_Wr, 1);
        cyc();

        // Rt-only hazard
        EX_Rt = 7; ID_Rt = 7; ID_Rs = 3; ID_UsesRt = 0;
        #1;
        lit("rt_nouse_pcwr", PC_Wr, 1);
        cyc();
        ID_UsesRt = 1;
        #1;
        lit("rt_use_pcwr", PC_Wr, 0);
        cyc();

        // redirect beats load-use
        do_reset();
        EX_MemtoReg = 1; EX_RegWr = 1; EX_Rt = 9; ID_Rs = 9;
        Branch_taken = 1;
        #1;
        lit("redir_flush", IFID_Flush, 1);
        lit("redir_bubble", IDEX_Bubble, 1);
        lit("redir_pcwr", PC_Wr, 1);
        cyc();
        clr_in();
        #1;
        lit("redir_cnt", Redir_cnt, 1);
        lit("redir_stall", Stall_cnt, 0);

        // memory wait with a frozen jump in EX
        do_reset();
        Mem_busy = 1; Jump_EX = 1;
        #1;
        lit("mw_hold", IDEX_Hold, 1);
        lit("mw_pcwr", PC_Wr, 0);
        cyc(); cyc(); cyc();
        Mem_busy = 0;
        #1;
        lit("mw_flush", IFID_Flush, 1);
        lit("mw_pc_redir", PC_Wr, 1);
        cyc();
        Jump_EX = 0;
        #1;
        lit("mw_stall", Stall_cnt, 3);
        lit("mw_redir", Redir_cnt, 1);

        // timeout to ERR
        do_reset();
        Mem_busy = 1;
        cyc(); cyc(); cyc();
        lit("to_err_early", Mem_err, 0);
        cyc();
        lit("to_err_set", Mem_err, 1);
        Mem_busy = 0; Branch_taken = 1;
        #1;
        lit("err_hold", IDEX_Hold, 1);
        lit("err_pcwr", PC_Wr, 0);
        cyc();
        Branch_taken = 0;
        cyc();
        lit("err_redir", Redir_cnt, 0);
        rst_n = 1'b0;
        #1;
        lit("err_rst_clear", Mem_err, 0);
        lit("err_rst_flush", IFID_Flush, 1);
        cyc();
        rst_n = 1'b1;
        cyc();
        lit("after_err_pcwr", PC_Wr, 1);

        // saturation of Stall_cnt
        do_reset();
        EX_MemtoReg = 1; EX_RegWr = 1; EX_Rt = 12; ID_Rt = 12; ID_UsesRt = 1;
        repeat (20) cyc();
        lit("sat_stall", Stall_cnt, 15);
        clr_in();

        // asynchronous reset in MWAIT
        cyc();
        Mem_busy = 1;
        cyc(); cyc();
        #1;
        rst_n = 1'b0;
        #1;
        lit("async_pcwr", PC_Wr, 0);
        lit("async_flush", IFID_Flush, 1);
        lit("async_bubble", IDEX_Bubble, 1);
        lit("async_hold", IDEX_Hold, 0);
        lit("async_stall", Stall_cnt, 0);
        cyc();
        Mem_busy = 0;
        rst_n = 1'b1;
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
